// File: rtl/voting_machine_multi_if.sv
// voting_machine_multi_if: panel-side and display-side signals of the voting machine
interface voting_machine_multi_if #(
    parameter int NUM_CAND = 4,
    parameter int LED_W    = 8
);
    logic                        mode;
    logic [NUM_CAND-1:0]         button;
    logic [LED_W-1:0]            led;
    logic                        vote_valid;
    logic [$clog2(NUM_CAND)-1:0] winner;
    logic                        tie;
    logic                        overflow;

    modport master (output mode, button, input led, vote_valid, winner, tie, overflow);
    modport slave  (input mode, button, output led, vote_valid, winner, tie, overflow);
endinterface

// File: rtl/voting_machine_multi.sv
// voting_machine_multi: debounced one-vote-per-press counter with leader/tie tracking and result display
module voting_machine_multi #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10,
    parameter int LED_W       = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    voting_machine_multi_if.slave  bus
);
    localparam int IW = $clog2(NUM_CAND);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] SAT = '1;

    typedef enum logic [1:0] {IDLE, COUNT, REJECT, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q [NUM_CAND];
    logic [CNT_W-1:0] max_v;
    logic [LED_W-1:0] led_q, led_d;
    logic [IW-1:0]    win_q, win_d, low_idx;
    logic             tie_q, tie_d, valid_q, ovf_q;
    logic             accept, any_btn, one_hot, sole;

    assign any_btn = |bus.button;
    assign one_hot = any_btn && ((bus.button & (bus.button - NUM_CAND'(1))) == '0);
    assign sole    = bus.button == (NUM_CAND'(1) << idx_q);

    // lowest-index high button, used both to latch a press and to pick the displayed count
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--)
            if (bus.button[i]) low_idx = IW'(i);
    end

    // press FSM: debounce a single button, reject multi-presses, one vote per press
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (!bus.mode && any_btn) begin
                state_d = one_hot ? COUNT : REJECT;
                idx_d   = low_idx;
                hold_d  = HW'(1);
            end
            COUNT: if (bus.mode) state_d = RELEASE;
                else if (sole) begin
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        accept  = 1'b1;
                        state_d = RELEASE;
                    end else hold_d = hold_q + HW'(1);
                end else state_d = bus.button[idx_q] ? REJECT : IDLE;
            default: if (!any_btn) state_d = IDLE;
        endcase
    end

    // leader search over the registered counts; strict compare keeps the lowest index on equality
    always_comb begin
        max_v = cnt_q[0];
        win_d = '0;
        tie_d = 1'b0;
        for (int i = 1; i < NUM_CAND; i++)
            if (cnt_q[i] > max_v) begin
                max_v = cnt_q[i];
                win_d = IW'(i);
            end
        for (int i = 0; i < NUM_CAND; i++)
            if (IW'(i) != win_d && cnt_q[i] == max_v) tie_d = 1'b1;
        tie_d = tie_d && (max_v != '0);
    end

    // display: cleared in voting mode, otherwise follows the lowest pressed button and holds when none
    always_comb led_d = !bus.mode ? '0 : any_btn ? LED_W'(cnt_q[low_idx]) : led_q;

    // saturating per-candidate vote counters
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
        end else if (accept && cnt_q[idx_q] != SAT) begin
            cnt_q[idx_q] <= cnt_q[idx_q] + CNT_W'(1);
        end
    end

    // FSM state, press bookkeeping and registered outputs
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            led_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            win_q   <= '0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
            valid_q <= accept;
            ovf_q   <= ovf_q | (accept && cnt_q[idx_q] == SAT);
            win_q   <= win_d;
            tie_q   <= tie_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.vote_valid = valid_q;
    assign bus.winner     = win_q;
    assign bus.tie        = tie_q;
    assign bus.overflow   = ovf_q;
endmodule
